// File: rtl/regfile_writeback_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_writeback_pkg
// Purpose  : Shared constants for the register-file writeback queue.
// Revision : 1.0
// ============================================================================
package regfile_writeback_pkg;

  localparam int C_DEPTH_DEF = 4;
  localparam int C_AW_DEF    = 5;
  localparam int C_DW_DEF    = 32;

  // $zero is hard-wired in the register file and must never be written.
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage
`default_nettype wire

// File: rtl/regfile_writeback_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_writeback_if
// Purpose  : Result inputs, register-file write port and bypass lookup bundle.
// Revision : 1.0
// ============================================================================
interface regfile_writeback_if
  import regfile_writeback_pkg::*;
#(
  parameter int AW = C_AW_DEF,
  parameter int DW = C_DW_DEF
);

  logic          MemValid;
  logic [AW-1:0] MemReg;
  logic [DW-1:0] MemData;
  logic          AluValid;
  logic [AW-1:0] AluReg;
  logic [DW-1:0] AluData;
  logic          InReady;
  logic          Write1;
  logic [AW-1:0] WriteReg1;
  logic [DW-1:0] WriteData1;
  logic [AW-1:0] RegA1;
  logic [AW-1:0] RegB1;
  logic [AW-1:0] RegC1;
  logic          HitA;
  logic          HitB;
  logic          HitC;
  logic [DW-1:0] BypA;
  logic [DW-1:0] BypB;
  logic [DW-1:0] BypC;
  logic          Overflow;

  modport master (
    output MemValid, MemReg, MemData, AluValid, AluReg, AluData,
    output RegA1, RegB1, RegC1,
    input  InReady, Write1, WriteReg1, WriteData1,
    input  HitA, HitB, HitC, BypA, BypB, BypC, Overflow
  );

  modport slave (
    input  MemValid, MemReg, MemData, AluValid, AluReg, AluData,
    input  RegA1, RegB1, RegC1,
    output InReady, Write1, WriteReg1, WriteData1,
    output HitA, HitB, HitC, BypA, BypB, BypC, Overflow
  );

endinterface
`default_nettype wire

// File: rtl/regfile_writeback_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Purpose  : Circular buffer with 0-2 pushes and 0-1 pop per cycle; exposes
//            storage, head and count for the bypass search.
// Revision : 1.0
// ============================================================================
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = PW + 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [1:0]    i_push_cnt,
  input  logic [W-1:0]  i_push_data0,
  input  logic [W-1:0]  i_push_data1,
  input  logic          i_pop,
  output logic [W-1:0]  o_entries [DEPTH],
  output logic [PW-1:0] o_head,
  output logic [CW-1:0] o_count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d = mem_q;
    if (i_push_cnt != 2'd0) begin
      mem_d[tail_q] = i_push_data0;
    end
    // Second push lands in the slot after the first; pointer wraps with DEPTH a power of 2.
    if (i_push_cnt == 2'd2) begin
      mem_d[tail_q + PW'(1)] = i_push_data1;
    end
    tail_d  = tail_q + PW'(i_push_cnt);
    head_d  = i_pop ? head_q + PW'(1) : head_q;
    count_d = count_q + CW'(i_push_cnt) - CW'(i_pop);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  assign o_entries = mem_q;
  assign o_head    = head_q;
  assign o_count   = count_q;

endmodule
`default_nettype wire

// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module   : regfile_writeback
// Purpose  : Orders ALU/load results into a queue feeding the single
//            register-file write port, with 3-way bypass lookup.
// Revision : 1.0
// ============================================================================
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int DEPTH = C_DEPTH_DEF,
  parameter int AW    = C_AW_DEF,
  parameter int DW    = C_DW_DEF
) (
  input  logic               CLK,
  input  logic               RESET,
  regfile_writeback_if.slave bus
);

  localparam int              PW      = $clog2(DEPTH);
  localparam int              CW      = PW + 1;
  localparam int              EW      = AW + DW;
  localparam logic [CW-1:0]   C_DEPTH = CW'(DEPTH);
  localparam logic [AW-1:0]   C_ZERO  = AW'(REG_ZERO);

  logic [EW-1:0] w_entries [DEPTH];
  logic [PW-1:0] w_head;
  logic [CW-1:0] w_count;
  logic          w_in_ready;
  logic          w_mem_take;
  logic          w_alu_take;
  logic          w_pop;
  logic [1:0]    w_push_cnt;
  logic [EW-1:0] w_push0;
  logic [EW-1:0] w_push1;

  logic          write_q, write_d;
  logic [AW-1:0] wreg_q, wreg_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          overflow_q, overflow_d;

  logic [PW-1:0] w_slot [DEPTH];
  logic          w_live [DEPTH];
  logic [AW-1:0] w_query [3];
  logic          w_hit [3];
  logic [DW-1:0] w_byp [3];

  // Readiness comes only from the registered count, never from the Valid inputs.
  assign w_in_ready = (C_DEPTH - w_count) >= CW'(2);

  always_comb begin
    w_mem_take = bus.MemValid && w_in_ready && (bus.MemReg != C_ZERO);
    w_alu_take = bus.AluValid && w_in_ready && (bus.AluReg != C_ZERO);
    // The load is the older instruction, so it takes the first slot when present.
    w_push0    = w_mem_take ? {bus.MemReg, bus.MemData} : {bus.AluReg, bus.AluData};
    w_push1    = {bus.AluReg, bus.AluData};
    w_push_cnt = {1'b0, w_mem_take} + {1'b0, w_alu_take};
    w_pop      = (w_count != '0);
  end

  wb_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .CLK          (CLK),
    .RESET        (RESET),
    .i_push_cnt   (w_push_cnt),
    .i_push_data0 (w_push0),
    .i_push_data1 (w_push1),
    .i_pop        (w_pop),
    .o_entries    (w_entries),
    .o_head       (w_head),
    .o_count      (w_count)
  );

  always_comb begin
    write_d    = w_pop;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    if (w_pop) begin
      {wreg_d, wdata_d} = w_entries[w_head];
    end
    overflow_d = overflow_q || ((bus.MemValid || bus.AluValid) && !w_in_ready);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      write_q    <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      write_q    <= write_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_slot[i] = w_head + PW'(i);
      w_live[i] = CW'(i) < w_count;
    end
  end

  assign w_query[0] = bus.RegA1;
  assign w_query[1] = bus.RegB1;
  assign w_query[2] = bus.RegC1;

  // Scan oldest to youngest so the last match (youngest write) wins.
  always_comb begin
    for (int q = 0; q < 3; q++) begin
      w_hit[q] = 1'b0;
      w_byp[q] = '0;
      if (w_query[q] != C_ZERO) begin
        if (write_q && (wreg_q == w_query[q])) begin
          w_hit[q] = 1'b1;
          w_byp[q] = wdata_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
          if (w_live[i] && (w_entries[w_slot[i]][EW-1:DW] == w_query[q])) begin
            w_hit[q] = 1'b1;
            w_byp[q] = w_entries[w_slot[i]][DW-1:0];
          end
        end
      end
    end
  end

  assign bus.InReady    = w_in_ready;
  assign bus.Write1     = write_q;
  assign bus.WriteReg1  = wreg_q;
  assign bus.WriteData1 = wdata_q;
  assign bus.Overflow   = overflow_q;
  assign bus.HitA       = w_hit[0];
  assign bus.HitB       = w_hit[1];
  assign bus.HitC       = w_hit[2];
  assign bus.BypA       = w_byp[0];
  assign bus.BypB       = w_byp[1];
  assign bus.BypC       = w_byp[2];

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_writeback
// Purpose  : Directed bench with a queue-level reference model for regfile_writeback.
// Revision : 1.0
// ============================================================================
module tb_regfile_writeback;

  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  regfile_writeback_if #(.AW(5), .DW(32)) bus ();

  regfile_writeback #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  // Reference: list of accepted-but-unissued writes plus the last issued write.
  ent_t        mq[$];
  logic        m_w1;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  logic        m_ovf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_byp(input logic [4:0] q, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = 32'h0;
    if (q != 5'd0) begin
      if (m_w1 && m_reg == q) begin
        hit = 1'b1;
        d   = m_data;
      end
      foreach (mq[i]) begin
        if (mq[i].r == q) begin
          hit = 1'b1;
          d   = mq[i].d;
        end
      end
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_w1   = 1'b0;
      m_reg  = 5'd0;
      m_data = 32'h0;
      m_ovf  = 1'b0;
    end else begin
      bit   rdy;
      ent_t e;
      rdy = (DEPTH - mq.size()) >= 2;
      if ((bus.MemValid || bus.AluValid) && !rdy) m_ovf = 1'b1;
      m_w1 = (mq.size() > 0);
      if (m_w1) begin
        e      = mq.pop_front();
        m_reg  = e.r;
        m_data = e.d;
      end
      if (rdy && bus.MemValid && bus.MemReg != 5'd0) begin
        e.r = bus.MemReg; e.d = bus.MemData; mq.push_back(e);
      end
      if (rdy && bus.AluValid && bus.AluReg != 5'd0) begin
        e.r = bus.AluReg; e.d = bus.AluData; mq.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      logic        h;
      logic [31:0] d;
      chk("cyc_InReady", 64'(bus.InReady), 64'((DEPTH - mq.size()) >= 2));
      chk("cyc_Write1", 64'(bus.Write1), 64'(m_w1));
      chk("cyc_WriteReg1", 64'(bus.WriteReg1), 64'(m_reg));
      chk("cyc_WriteData1", 64'(bus.WriteData1), 64'(m_data));
      chk("cyc_Overflow", 64'(bus.Overflow), 64'(m_ovf));
      model_byp(bus.RegA1, h, d);
      chk("cyc_HitA", 64'(bus.HitA), 64'(h));
      chk("cyc_BypA", 64'(bus.BypA), 64'(d));
      model_byp(bus.RegB1, h, d);
      chk("cyc_HitB", 64'(bus.HitB), 64'(h));
      chk("cyc_BypB", 64'(bus.BypB), 64'(d));
      model_byp(bus.RegC1, h, d);
      chk("cyc_HitC", 64'(bus.HitC), 64'(h));
      chk("cyc_BypC", 64'(bus.BypC), 64'(d));
    end
  end

  task automatic idle();
    bus.MemValid = 1'b0; bus.MemReg = 5'd0; bus.MemData = 32'h0;
    bus.AluValid = 1'b0; bus.AluReg = 5'd0; bus.AluData = 32'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mv, input logic [4:0] mr, input logic [31:0] md,
                       input logic av, input logic [4:0] ar, input logic [31:0] ad);
    bus.MemValid = mv; bus.MemReg = mr; bus.MemData = md;
    bus.AluValid = av; bus.AluReg = ar; bus.AluData = ad;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle();
    bus.RegA1 = 5'd0; bus.RegB1 = 5'd0; bus.RegC1 = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_Write1", 64'(bus.Write1), 64'd0);
    chk("rst_WriteReg1", 64'(bus.WriteReg1), 64'd0);
    chk("rst_WriteData1", 64'(bus.WriteData1), 64'd0);
    chk("rst_InReady", 64'(bus.InReady), 64'd1);
    chk("rst_Overflow", 64'(bus.Overflow), 64'd0);
    step();

    // Single write with one-cycle latency to the port.
    bus.RegA1 = 5'd5; bus.RegC1 = 5'd9;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF);
    step();
    idle();
    chk("single_w1_e0", 64'(bus.Write1), 64'd0);
    chk("single_hitA_e0", 64'(bus.HitA), 64'd1);
    chk("single_bypA_e0", 64'(bus.BypA), 64'hDEADBEEF);
    step();
    chk("single_w1_e1", 64'(bus.Write1), 64'd1);
    chk("single_reg_e1", 64'(bus.WriteReg1), 64'd5);
    chk("single_data_e1", 64'(bus.WriteData1), 64'hDEADBEEF);
    step();
    chk("single_w1_e2", 64'(bus.Write1), 64'd0);
    chk("single_hold_reg", 64'(bus.WriteReg1), 64'd5);

    // MEM is older than ALU in the same cycle.
    bus.RegA1 = 5'd3; bus.RegB1 = 5'd4;
    drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
    step();
    idle();
    step();
    chk("order_first_w1", 64'(bus.Write1), 64'd1);
    chk("order_first_reg", 64'(bus.WriteReg1), 64'd3);
    chk("order_first_data", 64'(bus.WriteData1), 64'h11);
    step();
    chk("order_second_reg", 64'(bus.WriteReg1), 64'd4);
    chk("order_second_data", 64'(bus.WriteData1), 64'h22);
    step();
    chk("order_done_w1", 64'(bus.Write1), 64'd0);

    // $zero is accepted but never written or bypassed.
    bus.RegA1 = 5'd0;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h55);
    step();
    idle();
    chk("zero_hitA", 64'(bus.HitA), 64'd0);
    step();
    chk("zero_w1_e1", 64'(bus.Write1), 64'd0);
    step();
    chk("zero_w1_e2", 64'(bus.Write1), 64'd0);

    // Youngest pending write to reg 7 is bypassed.
    bus.RegB1 = 5'd7;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hA);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hB);
    step();
    idle();
    chk("byp_hitB_e1", 64'(bus.HitB), 64'd1);
    chk("byp_bypB_e1", 64'(bus.BypB), 64'hB);
    step();
    step();
    chk("byp_hitB_after", 64'(bus.HitB), 64'd0);
    chk("byp_bypB_after", 64'(bus.BypB), 64'd0);

    // Fill to DEPTH-1, then a dropped input raises sticky Overflow.
    bus.RegA1 = 5'd5; bus.RegB1 = 5'd4; bus.RegC1 = 5'd2;
    drive(1'b1, 5'd1, 32'h100, 1'b1, 5'd2, 32'h200);
    step();
    drive(1'b1, 5'd3, 32'h300, 1'b1, 5'd4, 32'h400);
    step();
    chk("full_inready", 64'(bus.InReady), 64'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h500);
    step();
    idle();
    chk("full_overflow", 64'(bus.Overflow), 64'd1);
    chk("full_dropped_hitA", 64'(bus.HitA), 64'd0);
    repeat (5) step();
    chk("full_overflow_sticky", 64'(bus.Overflow), 64'd1);
    chk("full_drained_w1", 64'(bus.Write1), 64'd0);
    chk("full_last_reg", 64'(bus.WriteReg1), 64'd4);

    // Asynchronous reset mid-stream.
    bus.RegA1 = 5'd10;
    drive(1'b1, 5'd10, 32'hAA, 1'b1, 5'd11, 32'hBB);
    step();
    idle();
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("async_Write1", 64'(bus.Write1), 64'd0);
    chk("async_InReady", 64'(bus.InReady), 64'd1);
    chk("async_HitA", 64'(bus.HitA), 64'd0);
    chk("async_Overflow", 64'(bus.Overflow), 64'd0);
    #2;
    rst = 1'b0;
    repeat (3) step();
    chk("post_rst_w1", 64'(bus.Write1), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
